// File: rtl/wb_snoop_ctrl.sv
// Purpose: snoop sequencer; broadcasts one read-miss address to the data caches and reduces
//          their ack/hit replies to a single hit/miss result with owner and data.
// Latency: req edge -> COLLECT, deciding ack edge -> RESP (done_o), then IDLE; empty mask 1 edge.
// Backpressure: one request at a time (req_i sampled only in IDLE); the timeout bounds COLLECT.
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; req_* request from the arbiter;
//        abort_i cancel; busy_o/done_o/hit_o/timeout_o/owner_o/dat_o result;
//        snoop_* per-cache broadcast address, type and ack/hit/data responses.
module wb_snoop_ctrl #(
    parameter int aw       = 32,
    parameter int dw       = 32,
    parameter int num_dbus = 2,
    parameter int timeout  = 15
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     req_i,
    input  logic [aw-1:0]            req_adr_i,
    input  logic [num_dbus-1:0]      req_mask_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     hit_o,
    output logic                     timeout_o,
    output logic [num_dbus-1:0]      owner_o,
    output logic [dw-1:0]            dat_o,
    output logic [num_dbus*aw-1:0]   snoop_adr_o,
    output logic                     snoop_type_o,
    input  logic [num_dbus-1:0]      snoop_ack_i,
    input  logic [num_dbus-1:0]      snoop_hit_i,
    input  logic [num_dbus*dw-1:0]   snoop_dat_i
);

    localparam int TW = $clog2(timeout + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        COLLECT = 3'b010,
        RESP    = 3'b100
    } state_t;

    state_t                state_q;
    logic [aw-1:0]         adr_q;
    logic [num_dbus-1:0]   pending_q;
    logic [TW-1:0]         cnt_q;
    logic                  hit_q;
    logic                  timeout_q;
    logic [num_dbus-1:0]   owner_q;
    logic [dw-1:0]         dat_q;

    logic [num_dbus-1:0]   hit_vec;
    logic [num_dbus-1:0]   pending_d;
    logic [num_dbus-1:0]   owner_d;
    logic [dw-1:0]         dat_d;

    // Only lanes still pending may respond; acks on other lanes are ignored.
    assign hit_vec   = pending_q & snoop_ack_i & snoop_hit_i;
    assign pending_d = pending_q & ~snoop_ack_i;

    // Lowest-index hitting cache owns the line: scan downward so the lowest index wins.
    always_comb begin
        owner_d = '0;
        dat_d   = '0;
        for (int k = num_dbus - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                owner_d    = '0;
                owner_d[k] = 1'b1;
                dat_d      = snoop_dat_i[k*dw +: dw];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            timeout_q <= 1'b0;
            owner_q   <= '0;
            dat_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        adr_q     <= req_adr_i;
                        pending_q <= req_mask_i;
                        cnt_q     <= '0;
                        hit_q     <= 1'b0;
                        timeout_q <= 1'b0;
                        owner_q   <= '0;
                        dat_q     <= '0;
                        state_q   <= (req_mask_i == '0) ? RESP : COLLECT;
                    end
                end
                COLLECT: begin
                    if (abort_i) begin
                        state_q   <= IDLE;
                        pending_q <= '0;
                        hit_q     <= 1'b0;
                        timeout_q <= 1'b0;
                        owner_q   <= '0;
                        dat_q     <= '0;
                    end else begin
                        pending_q <= pending_d;
                        // Hit beats both "all answered" and timeout in the same cycle.
                        if (hit_vec != '0) begin
                            hit_q   <= 1'b1;
                            owner_q <= owner_d;
                            dat_q   <= dat_d;
                            state_q <= RESP;
                        end else if (pending_d == '0) begin
                            state_q <= RESP;
                        end else if (cnt_q == TW'(timeout - 1)) begin
                            timeout_q <= 1'b1;
                            state_q   <= RESP;
                        end else begin
                            cnt_q <= cnt_q + TW'(1);
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register so a reset clears them without waiting for an edge.
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == RESP);
    assign snoop_type_o = (state_q == COLLECT);
    assign snoop_adr_o  = (state_q == COLLECT) ? {num_dbus{adr_q}} : '0;
    assign hit_o        = hit_q;
    assign timeout_o    = timeout_q;
    assign owner_o      = owner_q;
    assign dat_o        = dat_q;

endmodule

// File: tb/tb_wb_snoop_ctrl.sv
module tb_wb_snoop_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 2;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            req_i;
    logic [AW-1:0]   req_adr_i;
    logic [N-1:0]    req_mask_i;
    logic            abort_i;
    logic [N-1:0]    snoop_ack_i;
    logic [N-1:0]    snoop_hit_i;
    logic [N*DW-1:0] snoop_dat_i;

    // default instance (timeout 15)
    logic            busy_o, done_o, hit_o, timeout_o, snoop_type_o;
    logic [N-1:0]    owner_o;
    logic [DW-1:0]   dat_o;
    logic [N*AW-1:0] snoop_adr_o;
    // short-timeout instance (timeout 4), same stimulus
    logic            busy4, done4, hit4, timeout4, snoop_type4;
    logic [N-1:0]    owner4;
    logic [DW-1:0]   dat4;
    logic [N*AW-1:0] snoop_adr4;

    int checks = 0;
    int errors = 0;

    wb_snoop_ctrl #(.aw(AW), .dw(DW), .num_dbus(N), .timeout(15)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_i(req_i), .req_adr_i(req_adr_i), .req_mask_i(req_mask_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .hit_o(hit_o), .timeout_o(timeout_o),
        .owner_o(owner_o), .dat_o(dat_o), .snoop_adr_o(snoop_adr_o), .snoop_type_o(snoop_type_o),
        .snoop_ack_i(snoop_ack_i), .snoop_hit_i(snoop_hit_i), .snoop_dat_i(snoop_dat_i)
    );

    wb_snoop_ctrl #(.aw(AW), .dw(DW), .num_dbus(N), .timeout(4)) dut4 (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_i(req_i), .req_adr_i(req_adr_i), .req_mask_i(req_mask_i), .abort_i(abort_i),
        .busy_o(busy4), .done_o(done4), .hit_o(hit4), .timeout_o(timeout4),
        .owner_o(owner4), .dat_o(dat4), .snoop_adr_o(snoop_adr4), .snoop_type_o(snoop_type4),
        .snoop_ack_i(snoop_ack_i), .snoop_hit_i(snoop_hit_i), .snoop_dat_i(snoop_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Advance past the next rising edge; outputs are stable when this returns.
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] adr, input logic [N-1:0] mask);
        req_i      = 1'b1;
        req_adr_i  = adr;
        req_mask_i = mask;
        step();
        req_i      = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1; req_i = 1'b0; req_adr_i = '0; req_mask_i = '0; abort_i = 1'b0;
        snoop_ack_i = '0; snoop_hit_i = '0; snoop_dat_i = '0;
        #12;
        checks++;
        if ({busy_o, done_o, hit_o, timeout_o, snoop_type_o, owner_o, dat_o, snoop_adr_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b hit=%b to=%b type=%b owner=%b dat=%h adr=%h, required all 0",
                     busy_o, done_o, hit_o, timeout_o, snoop_type_o, owner_o, dat_o, snoop_adr_o);
        end
        wb_rst_i = 1'b0;
        step();
    endtask

    task automatic test_miss_all_neg();
        issue(32'h1000, 2'b11);
        checks++;
        if ({busy_o, done_o, snoop_type_o, snoop_adr_o} !== {1'b1, 1'b0, 1'b1, 32'h1000, 32'h1000}) begin
            errors++;
            $display("FAIL miss_collect: busy=%b done=%b type=%b adr=%h, required 1 0 1 %h",
                     busy_o, done_o, snoop_type_o, snoop_adr_o, {32'h1000, 32'h1000});
        end
        snoop_ack_i = 2'b11; snoop_hit_i = 2'b00;
        step();
        snoop_ack_i = '0;
        checks++;
        if ({done_o, hit_o, timeout_o, owner_o, dat_o} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL miss_result: done=%b hit=%b to=%b owner=%b dat=%h, required 1 0 0 00 0",
                     done_o, hit_o, timeout_o, owner_o, dat_o);
        end
        step();
        checks++;
        if ({busy_o, done_o, snoop_type_o, snoop_adr_o} !== '0) begin
            errors++;
            $display("FAIL miss_idle: busy=%b done=%b type=%b adr=%h, required all 0",
                     busy_o, done_o, snoop_type_o, snoop_adr_o);
        end
    endtask

    task automatic test_hit_single();
        issue(32'h1040, 2'b11);
        snoop_ack_i = 2'b10; snoop_hit_i = 2'b10; snoop_dat_i = {32'hDEADBEEF, 32'h0};
        step();
        snoop_ack_i = '0; snoop_hit_i = '0; snoop_dat_i = '0;
        checks++;
        if ({done_o, hit_o, timeout_o, owner_o, dat_o} !== {1'b1, 1'b1, 1'b0, 2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL hit1_result: done=%b hit=%b to=%b owner=%b dat=%h, required 1 1 0 10 deadbeef",
                     done_o, hit_o, timeout_o, owner_o, dat_o);
        end
        step();
        checks++;
        if ({busy_o, done_o, hit_o, owner_o, dat_o} !== {1'b0, 1'b0, 1'b1, 2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL hit1_hold: busy=%b done=%b hit=%b owner=%b dat=%h, required 0 0 1 10 deadbeef",
                     busy_o, done_o, hit_o, owner_o, dat_o);
        end
    endtask

    task automatic test_hit_priority();
        // both hit together: lowest index owns
        issue(32'h2000, 2'b11);
        checks++;
        if ({hit_o, owner_o, dat_o} !== '0) begin
            errors++;
            $display("FAIL accept_clears: hit=%b owner=%b dat=%h, required 0 00 0", hit_o, owner_o, dat_o);
        end
        snoop_ack_i = 2'b11; snoop_hit_i = 2'b11; snoop_dat_i = {32'h22, 32'h11};
        step();
        checks++;
        if ({done_o, hit_o, owner_o, dat_o} !== {1'b1, 1'b1, 2'b01, 32'h11}) begin
            errors++;
            $display("FAIL both_hit: done=%b hit=%b owner=%b dat=%h, required 1 1 01 11",
                     done_o, hit_o, owner_o, dat_o);
        end
        snoop_ack_i = '0; snoop_hit_i = '0; snoop_dat_i = '0;
        step();
        // hit on lane 1 plus negative last ack on lane 0 in the same cycle: hit wins
        issue(32'h2100, 2'b11);
        snoop_ack_i = 2'b11; snoop_hit_i = 2'b10; snoop_dat_i = {32'h77, 32'h66};
        step();
        checks++;
        if ({done_o, hit_o, owner_o, dat_o} !== {1'b1, 1'b1, 2'b10, 32'h77}) begin
            errors++;
            $display("FAIL hit_vs_neg: done=%b hit=%b owner=%b dat=%h, required 1 1 10 77",
                     done_o, hit_o, owner_o, dat_o);
        end
        snoop_ack_i = '0; snoop_hit_i = '0; snoop_dat_i = '0;
        step();
        // non-participating cache 0 hits: ignored
        issue(32'h2200, 2'b10);
        snoop_ack_i = 2'b01; snoop_hit_i = 2'b01; snoop_dat_i = {32'h0, 32'h55};
        step();
        checks++;
        if ({busy_o, done_o, snoop_type_o} !== 3'b101) begin
            errors++;
            $display("FAIL masked_ack: busy=%b done=%b type=%b, required 1 0 1", busy_o, done_o, snoop_type_o);
        end
        snoop_ack_i = 2'b10; snoop_hit_i = 2'b00; snoop_dat_i = '0;
        step();
        snoop_ack_i = '0;
        checks++;
        if ({done_o, hit_o, timeout_o, owner_o, dat_o} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL masked_miss: done=%b hit=%b to=%b owner=%b dat=%h, required 1 0 0 00 0",
                     done_o, hit_o, timeout_o, owner_o, dat_o);
        end
        step();
    endtask

    task automatic test_timeout_short();
        issue(32'h3000, 2'b01);
        repeat (3) step();
        checks++;
        if ({busy4, done4, snoop_type4} !== 3'b101) begin
            errors++;
            $display("FAIL to4_early: busy=%b done=%b type=%b after 3 collect edges, required 1 0 1",
                     busy4, done4, snoop_type4);
        end
        step();
        checks++;
        if ({done4, timeout4, hit4, owner4, dat4} !== {1'b1, 1'b1, 1'b0, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL to4_result: done=%b to=%b hit=%b owner=%b dat=%h, required 1 1 0 00 0",
                     done4, timeout4, hit4, owner4, dat4);
        end
        snoop_ack_i = 2'b01; snoop_hit_i = 2'b01; snoop_dat_i = {32'h0, 32'hAA};
        step();
        snoop_ack_i = '0; snoop_hit_i = '0; snoop_dat_i = '0;
        checks++;
        if ({busy4, done4, timeout4, hit4, dat4} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL to4_late_ack: busy=%b done=%b to=%b hit=%b dat=%h, required 0 0 1 0 0",
                     busy4, done4, timeout4, hit4, dat4);
        end
        repeat (2) step();
    endtask

    task automatic test_timeout_default();
        issue(32'h3100, 2'b10);
        repeat (14) step();
        checks++;
        if ({busy_o, done_o} !== 2'b10) begin
            errors++;
            $display("FAIL to15_early: busy=%b done=%b after 14 collect edges, required 1 0", busy_o, done_o);
        end
        step();
        checks++;
        if ({done_o, timeout_o, hit_o} !== 3'b110) begin
            errors++;
            $display("FAIL to15_result: done=%b to=%b hit=%b, required 1 1 0", done_o, timeout_o, hit_o);
        end
        step();
    endtask

    task automatic test_abort();
        issue(32'h4000, 2'b11);
        step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        checks++;
        if ({busy_o, done_o, snoop_type_o, snoop_adr_o, hit_o, timeout_o} !== '0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b type=%b adr=%h hit=%b to=%b, required all 0",
                     busy_o, done_o, snoop_type_o, snoop_adr_o, hit_o, timeout_o);
        end
        issue(32'h5000, 2'b01);
        checks++;
        if ({snoop_type_o, snoop_adr_o} !== {1'b1, 32'h5000, 32'h5000}) begin
            errors++;
            $display("FAIL abort_new_req: type=%b adr=%h, required 1 %h",
                     snoop_type_o, snoop_adr_o, {32'h5000, 32'h5000});
        end
        snoop_ack_i = 2'b01; snoop_hit_i = 2'b00;
        step();
        snoop_ack_i = '0;
        checks++;
        if ({done_o, hit_o} !== 2'b10) begin
            errors++;
            $display("FAIL abort_followup: done=%b hit=%b, required 1 0", done_o, hit_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        issue(32'h6000, 2'b11);
        #2 wb_rst_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, snoop_type_o, snoop_adr_o, done_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b type=%b adr=%h done=%b, required all 0",
                     busy_o, snoop_type_o, snoop_adr_o, done_o);
        end
        #2 wb_rst_i = 1'b0;
        issue(32'h7000, 2'b00);
        checks++;
        if ({done_o, busy_o, hit_o, timeout_o, owner_o, snoop_type_o} !== {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL empty_mask: done=%b busy=%b hit=%b to=%b owner=%b type=%b, required 1 1 0 0 00 0",
                     done_o, busy_o, hit_o, timeout_o, owner_o, snoop_type_o);
        end
        step();
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL empty_mask_idle: done=%b busy=%b, required 0 0", done_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_miss_all_neg();
        test_hit_single();
        test_hit_priority();
        test_timeout_short();
        test_timeout_default();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
